// File: rtl/riscv_pkg.sv
// Shared load/store definitions: FSM state encoding, Funct3 codes,
// and lane helpers for byte enables, store replication and legality.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsupported codes and natural-alignment violations are illegal.
  function automatic logic f3_legal(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store data into every lane so the
  // byte enables alone pick the destination bytes.
  function automatic logic [31:0] lane_wdata(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] d;
    d = 32'h0;
    case (f3)
      F3_B, F3_BU: d = {4{wd[7:0]}};
      F3_H, F3_HU: d = {2{wd[15:0]}};
      F3_W:        d = wd;
      default:     d = 32'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load extraction: shifts the addressed field of a bus word down and
// sign/zero-extends it. Ports: i_word, i_offset, i_funct3 -> o_data.
module lsu_extend
  import riscv_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_field;

  assign w_field = i_word >> {i_offset, 3'b000};

  always_comb begin
    o_data = 32'h0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_field[7]}}, w_field[7:0]};
      F3_H:    o_data = {{16{w_field[15]}}, w_field[15:0]};
      F3_W:    o_data = w_field;
      F3_BU:   o_data = {24'h0, w_field[7:0]};
      F3_HU:   o_data = {16'h0, w_field[15:0]};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: bridges datapath memory requests to a simple
// req/ack bus with alignment checks, lane steering and a timeout.
// Ports: clk/reset; datapath MemReq, MemWrite, Funct3, ALUResult,
// WriteData -> ReadData, Stall, AccessErr, BusErr; bus BusReq,
// BusWe, BusAddr, BusWData, BusBE <- BusRData, BusAck.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  output logic        BusErr,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusBE,
  input  logic [31:0] BusRData,
  input  logic        BusAck
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t  r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_buserr;
  logic        r_busreq;

  logic        w_idle;
  logic        w_legal;
  logic        w_start;
  logic        w_illegal;
  logic [31:0] w_ext;

  assign w_idle    = (r_state == S_IDLE);
  assign w_legal   = f3_legal(Funct3, ALUResult[1:0]);
  assign w_start   = w_idle & MemReq & w_legal;
  assign w_illegal = w_idle & MemReq & ~w_legal;

  lsu_extend u_ext (
    .i_word   (BusRData),
    .i_offset (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_ext)
  );

  // Stall must rise in the request cycle itself so the PC holds.
  assign Stall     = w_start | (r_state == S_ACCESS);
  assign AccessErr = w_illegal;
  assign ReadData  = w_illegal ? 32'h0 : r_rdata;
  assign BusErr    = r_buserr;
  assign BusReq    = r_busreq;
  assign BusWe     = r_we;
  assign BusAddr   = r_addr;
  assign BusWData  = r_wdata;
  assign BusBE     = r_be;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= 32'h0;
      r_off    <= 2'b00;
      r_f3     <= 3'b000;
      r_we     <= 1'b0;
      r_be     <= 4'b0000;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_buserr <= 1'b0;
      r_busreq <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_buserr <= 1'b0;
          if (w_start) begin
            r_addr   <= {ALUResult[31:2], 2'b00};
            r_off    <= ALUResult[1:0];
            r_f3     <= Funct3;
            r_we     <= MemWrite;
            r_be     <= lane_be(Funct3, ALUResult[1:0]);
            r_wdata  <= lane_wdata(Funct3, WriteData);
            r_cnt    <= '0;
            r_busreq <= 1'b1;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // An ack in the final counted cycle still wins over timeout.
          if (BusAck) begin
            if (!r_we) r_rdata <= w_ext;
            r_busreq <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_cnt == TO_LAST) begin
            if (!r_we) r_rdata <= 32'h0;
            r_buserr <= 1'b1;
            r_busreq <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_buserr <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors plus
// randomized accesses against a behavioural memory-access model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AccessErr;
  logic        BusErr;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWData;
  logic [3:0]  BusBE;
  logic [31:0] BusRData;
  logic        BusAck;

  int passed = 0;
  int total  = 0;
  logic [31:0] m_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .AccessErr (AccessErr),
    .BusErr    (BusErr),
    .BusReq    (BusReq),
    .BusWe     (BusWe),
    .BusAddr   (BusAddr),
    .BusWData  (BusWData),
    .BusBE     (BusBE),
    .BusRData  (BusRData),
    .BusAck    (BusAck)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 > 3'd5) return 1'b0;
    return (a % size_of(f3)) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = size_of(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
    int n;
    n = size_of(f3);
    if (n == 1) return (wd & 32'hFF) * 32'h01010101;
    if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] field;
    int n;
    int v;
    n = size_of(f3);
    field = rd >> (8 * (a % 4));
    if (n == 4) return field;
    v = int'(field & ((32'd1 << (8 * n)) - 1));
    if (!f3[2] && v >= (1 << (8 * n - 1))) v = v - (1 << (8 * n));
    return 32'(v);
  endfunction

  // One full datapath request. ack_at: ACCESS cycle index carrying
  // BusAck, or anything >= TO for a timeout.
  task automatic access(input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_at,
                        output int stalls);
    bit ok;
    bit acked;
    ok = legal(f3, a);
    stalls = 0;
    acked = 1'b0;
    MemReq = 1'b1; MemWrite = we; Funct3 = f3;
    ALUResult = a; WriteData = wd; BusRData = rd; BusAck = 1'b0;
    #1;
    if (Stall) stalls++;
    total++;
    if (AccessErr !== !ok || Stall !== ok || BusReq !== 1'b0)
      $display("FAIL req_cycle a=%h f3=%b got err=%b stall=%b req=%b want err=%b stall=%b req=0",
               a, f3, AccessErr, Stall, BusReq, !ok, ok);
    else passed++;
    if (!ok) begin
      total++;
      if (ReadData !== 32'h0)
        $display("FAIL illegal_rdata got %h want 00000000", ReadData);
      else passed++;
      tick();
      MemReq = 1'b0;
      #1;
      total++;
      if (BusReq !== 1'b0 || Stall !== 1'b0 || ReadData !== m_rdata)
        $display("FAIL after_illegal got req=%b stall=%b rdata=%h want 0 0 %h",
                 BusReq, Stall, ReadData, m_rdata);
      else passed++;
      return;
    end
    tick();
    for (int k = 0; k < TO; k++) begin
      BusAck = (k == ack_at);
      #1;
      if (Stall) stalls++;
      total++;
      if (BusReq !== 1'b1 || Stall !== 1'b1 || BusWe !== we ||
          BusAddr !== (a & 32'hFFFF_FFFC) || BusBE !== exp_be(f3, a) ||
          (we && BusWData !== exp_wd(f3, wd)))
        $display("FAIL access_cyc%0d got req=%b st=%b we=%b ad=%h be=%b wd=%h want 1 1 %b %h %b %h",
                 k, BusReq, Stall, BusWe, BusAddr, BusBE, BusWData,
                 we, a & 32'hFFFF_FFFC, exp_be(f3, a), exp_wd(f3, wd));
      else passed++;
      tick();
      if (BusAck) begin
        acked = 1'b1;
        break;
      end
    end
    BusAck = 1'b0;
    BusRData = $urandom;
    if (!we) m_rdata = acked ? exp_load(f3, a, rd) : 32'h0;
    #1;
    if (Stall) stalls++;
    total++;
    if (Stall !== 1'b0 || BusReq !== 1'b0 || BusErr !== !acked || ReadData !== m_rdata)
      $display("FAIL done_cycle got st=%b req=%b berr=%b rdata=%h want 0 0 %b %h",
               Stall, BusReq, BusErr, ReadData, !acked, m_rdata);
    else passed++;
    tick();
    MemReq = 1'b0;
    #1;
    total++;
    if (Stall !== 1'b0 || BusReq !== 1'b0 || BusErr !== 1'b0 ||
        AccessErr !== 1'b0 || ReadData !== m_rdata)
      $display("FAIL back_idle got st=%b req=%b berr=%b aerr=%b rdata=%h want 0 0 0 0 %h",
               Stall, BusReq, BusErr, AccessErr, ReadData, m_rdata);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (ReadData !== 32'h0 || BusReq !== 1'b0 || BusErr !== 1'b0 ||
        AccessErr !== 1'b0 || Stall !== 1'b0)
      $display("FAIL reset_ctrl got rd=%h req=%b berr=%b aerr=%b st=%b want all 0",
               ReadData, BusReq, BusErr, AccessErr, Stall);
    else passed++;
    total++;
    if (BusAddr !== 32'h0 || BusBE !== 4'h0 || BusWData !== 32'h0 || BusWe !== 1'b0)
      $display("FAIL reset_bus got ad=%h be=%b wd=%h we=%b want all 0",
               BusAddr, BusBE, BusWData, BusWe);
    else passed++;
  endtask

  task automatic test_spec_vectors();
    int st;
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, st);
    total++;
    if (st != 3) $display("FAIL lw_stall_cycles got %0d want 3", st);
    else passed++;
    total++;
    if (ReadData !== 32'hDEADBEEF) $display("FAIL lw_value got %h want deadbeef", ReadData);
    else passed++;
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, st);
    total++;
    if (ReadData !== 32'hFFFFFF80) $display("FAIL lb_value got %h want ffffff80", ReadData);
    else passed++;
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, st);
    total++;
    if (ReadData !== 32'h00000080) $display("FAIL lbu_value got %h want 00000080", ReadData);
    else passed++;
    access(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, st);
    total++;
    if (BusBE !== 4'b1100 || BusWData !== 32'hABCDABCD || BusAddr !== 32'h200)
      $display("FAIL sh_lanes got be=%b wd=%h ad=%h want 1100 abcdabcd 00000200",
               BusBE, BusWData, BusAddr);
    else passed++;
    access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, st);
    access(1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, TO + 5, st);
    total++;
    if (ReadData !== 32'h0 || st != TO + 1)
      $display("FAIL lw_timeout got rd=%h stalls=%0d want 00000000 %0d",
               ReadData, st, TO + 1);
    else passed++;
    access(1'b0, 3'b001, 32'h006, 32'h0, 32'h9ABC0000, TO - 1, st);
  endtask

  task automatic test_ack_outside();
    MemReq = 1'b0;
    BusAck = 1'b1;
    BusRData = 32'hCAFEF00D;
    tick();
    tick();
    BusAck = 1'b0;
    #1;
    total++;
    if (ReadData !== m_rdata || BusReq !== 1'b0 || Stall !== 1'b0 || BusErr !== 1'b0)
      $display("FAIL stray_ack got rd=%h req=%b st=%b berr=%b want %h 0 0 0",
               ReadData, BusReq, Stall, BusErr, m_rdata);
    else passed++;
  endtask

  task automatic test_reset_in_access();
    MemReq = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010;
    ALUResult = 32'h40; BusRData = 32'h55AA55AA; BusAck = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    MemReq = 1'b0;
    m_rdata = 32'h0;
    BusAck = 1'b1;
    #1;
    total++;
    if (BusReq !== 1'b0 || Stall !== 1'b0 || ReadData !== 32'h0)
      $display("FAIL rst_access got req=%b st=%b rd=%h want 0 0 00000000",
               BusReq, Stall, ReadData);
    else passed++;
    tick();
    BusAck = 1'b0;
    #1;
    total++;
    if (ReadData !== 32'h0 || BusErr !== 1'b0 || BusReq !== 1'b0)
      $display("FAIL rst_late_ack got rd=%h berr=%b req=%b want 00000000 0 0",
               ReadData, BusErr, BusReq);
    else passed++;
  endtask

  task automatic test_random();
    int st;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 80; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 3) != 0) a[1] = 1'b0;
      access(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom,
             $urandom_range(0, TO + 1), st);
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  initial begin
    reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
    ALUResult = 32'h0; WriteData = 32'h0; BusRData = 32'h0; BusAck = 1'b0;
    m_rdata = 32'h0;
    test_reset();
    test_spec_vectors();
    test_ack_outside();
    test_reset_in_access();
    test_random();
    test_ack_outside();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, max ACCESS cycles awaiting BusAck before bus error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MemReq  input  1  datapath requests load/store; held stable while Stall=1.
REQ-005 MemWrite  input  1  1=store, 0=load.
REQ-006 Funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUResult  input  32  byte address.
REQ-008 WriteData  input  32  store data, right-aligned.
REQ-009 ReadData  output  32  aligned, extended load result to datapath result mux.
REQ-010 Stall  output  1  freezes PC and register write while high.
REQ-011 AccessErr  output  1  misaligned address or illegal Funct3.
REQ-012 BusErr  output  1  bus timeout indication.
REQ-013 BusReq, BusWe  output  1 each  bus request / write enable.
REQ-014 BusAddr  output  32  word-aligned address (bits[1:0]=00).
REQ-015 BusWData  output  32  lane-replicated store data.
REQ-016 BusBE  output  4  byte enables.
REQ-017 BusRData  input  32  read word; BusAck  input  1  completion strobe.

Function
REQ-018 FSM states IDLE, ACCESS, DONE SHALL be used; reset state IDLE.
REQ-019 IDLE, MemReq=1, access legal: Stall=1 combinationally; latch address, offset, Funct3, MemWrite, BE, BusWData; next ACCESS.
REQ-020 Illegal: Funct3 in {011,110,111}; H/HU with addr[0]=1; W with addr[1:0]!=00.
REQ-021 IDLE, MemReq=1, illegal: AccessErr=1 that cycle, Stall=0, ReadData=0, no bus request, state stays IDLE.
REQ-022 ACCESS: BusReq=1, Stall=1; BusAddr/BusWe/BusBE/BusWData held stable until BusAck or timeout.
REQ-023 ACCESS with BusAck=1: capture BusRData (loads); next DONE; BusReq=0 from next cycle.
REQ-024 Timeout counter clears on ACCESS entry, increments each ACCESS cycle; at TIMEOUT_CYCLES without BusAck, next DONE with BusErr=1, load result 0.
REQ-025 DONE: Stall=0, ReadData valid, BusErr valid one cycle; MemReq ignored; next IDLE.
REQ-026 Minimum access latency 3 cycles (IDLE, ACCESS, DONE) with BusAck in first ACCESS cycle.
REQ-027 BE: B = 0001<<addr[1:0]; H = 0011 (addr[1]=0) or 1100; W = 1111; same rule for loads and stores.
REQ-028 BusWData: B = {4{WriteData[7:0]}}; H = {2{WriteData[15:0]}}; W = WriteData.
REQ-029 Load extract: field = BusRData >> (8*offset); B/H sign-extend from bit 7/15; BU/HU zero-extend; W unchanged.
REQ-030 BusAck outside ACCESS SHALL be ignored; BusAck coincident with timeout counts as ack (BusErr=0).
REQ-031 MemReq=0 in IDLE: Stall=0, BusReq=0, AccessErr=0, ReadData holds last value.

Reset
REQ-032 Reset SHALL force IDLE, timeout counter 0, ReadData 0, BusReq 0, BusErr 0, AccessErr 0, latched BE/addr/data 0.
REQ-033 Reset during ACCESS SHALL drop BusReq in the cycle following the reset edge; pending BusAck discarded.

Structure
REQ-034 Shared package riscv_pkg SHALL hold FSM state encoding and Funct3 load/store constants.
REQ-035 Sub-module lsu_extend SHALL implement REQ-029 combinationally (inputs word, offset, Funct3).

Verification
REQ-036 LW addr 0x100, BusAck on 2nd ACCESS cycle, BusRData 0xDEADBEEF -> Stall 3 cycles, ReadData 0xDEADBEEF in DONE, BusBE 1111.
REQ-037 LB addr 0x103, BusRData 0x80123456 -> ReadData 0xFFFFFF80; LBU same -> 0x00000080; BusAddr 0x100.
REQ-038 SH addr 0x202, WriteData 0x0000ABCD -> BusBE 1100, BusWData 0xABCDABCD, BusWe 1, BusAddr 0x200.
REQ-039 LW addr 0x101 -> AccessErr 1 one cycle, Stall 0, BusReq never asserted.
REQ-040 LW, no BusAck, TIMEOUT_CYCLES=4 -> DONE after 4 ACCESS cycles, BusErr 1, ReadData 0, then IDLE.
REQ-041 Reset asserted in 2nd ACCESS cycle -> IDLE next cycle, BusReq 0, later BusAck causes no capture.
